// File: rtl/partybox_pkg.sv
// Shared types, limits and the rotating-priority helper for the party-game buzzer blocks.
package partybox_pkg;

  localparam int MAX_PLAYERS = 8;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    OPEN,
    LOCKED,
    TIMEOUT
  } buzz_state_t;

  // First requester at or after ptr, wrapping within numPlayers; 0 when nobody requests.
  function automatic logic [2:0] rrPick(input logic [MAX_PLAYERS-1:0] req,
                                        input logic [2:0] ptr,
                                        input int numPlayers);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      idx = 3'((int'(ptr) + i) % numPlayers);
      if (!found && (i < numPlayers) && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: two-flop synchronizer, stability counter and a
// one-cycle registered pulse on each debounced released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_keyN,
  output logic o_press
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_levelD;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // r_level is the debounced state with 1 = pressed; any agreement restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_level  <= 1'b0;
      r_levelD <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_keyN;
      r_sync2  <= r_sync1;
      r_levelD <= r_level;
      r_press  <= r_level & ~r_levelD;
      if (~r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= ~r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/buzz_arbiter.sv
// Quiz buzzer round controller: arm, get-ready hold, open window, first-press lockout.
// Define BUZZ_FALSE_START_EN to disqualify players who press during the hold period.
module buzz_arbiter
  import partybox_pkg::*;
#(
  parameter  int NUM_PLAYERS     = 4,
  parameter  int DEBOUNCE_CYCLES = 500000,
  parameter  int HOLD_CYCLES     = 50000000,
  parameter  int WINDOW_CYCLES   = 250000000,
  localparam int WID             = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NUM_PLAYERS-1:0] key_n,
  input  logic [NUM_PLAYERS-1:0] enable_mask,
  input  logic                   arm,
  input  logic                   clear,
  output buzz_state_t            state,
  output logic                   winner_valid,
  output logic [WID-1:0]         winner_id,
  output logic                   timeout,
  output logic [NUM_PLAYERS-1:0] led,
  output logic [NUM_PLAYERS-1:0] false_start
);

  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] WINDOW_LAST = 32'(WINDOW_CYCLES - 1);

  buzz_state_t            r_state;
  logic                   r_winnerValid;
  logic [WID-1:0]         r_winnerId;
  logic                   r_timeout;
  logic [2:0]             r_ptr;
  logic [31:0]            r_timer;
  logic [NUM_PLAYERS-1:0] r_mask;
  logic [NUM_PLAYERS-1:0] w_press;
  logic [NUM_PLAYERS-1:0] w_elig;
  logic [NUM_PLAYERS-1:0] w_falseStart;
  logic [NUM_PLAYERS-1:0] w_led;
  logic [MAX_PLAYERS-1:0] w_req;
  logic [2:0]             w_pick;
  logic [2:0]             w_ptrNext;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (clk_clk),
      .i_reset(reset_reset),
      .i_keyN (key_n[g]),
      .o_press(w_press[g])
    );
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_mask <= '0;
    else             r_mask <= enable_mask;
  end

  assign w_elig    = w_press & r_mask & ~w_falseStart;
  assign w_pick    = rrPick(w_req, r_ptr, NUM_PLAYERS);
  assign w_ptrNext = (int'(w_pick) == NUM_PLAYERS - 1) ? 3'd0 : w_pick + 3'd1;

  always_comb begin
    w_req                  = '0;
    w_req[NUM_PLAYERS-1:0] = w_elig;
  end

  // clear outranks everything else in the same cycle; the timer restarts on each state entry.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state       <= IDLE;
      r_winnerValid <= 1'b0;
      r_winnerId    <= '0;
      r_timeout     <= 1'b0;
      r_ptr         <= '0;
      r_timer       <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (clear) begin
        r_state       <= IDLE;
        r_winnerValid <= 1'b0;
        r_timer       <= '0;
      end else begin
        case (r_state)
          IDLE, TIMEOUT: begin
            if (arm) begin
              r_state <= HOLD;
              r_timer <= '0;
            end
          end
          HOLD: begin
            if (r_timer == HOLD_LAST) begin
              r_state <= OPEN;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 32'd1;
            end
          end
          OPEN: begin
            if (|w_elig) begin
              r_state       <= LOCKED;
              r_winnerValid <= 1'b1;
              r_winnerId    <= w_pick[WID-1:0];
              r_ptr         <= w_ptrNext;
              r_timer       <= '0;
            end else if (r_timer == WINDOW_LAST) begin
              r_state   <= TIMEOUT;
              r_timeout <= 1'b1;
              r_timer   <= '0;
            end else begin
              r_timer <= r_timer + 32'd1;
            end
          end
          LOCKED: ;
          default: begin
            r_state <= IDLE;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

`ifdef BUZZ_FALSE_START_EN
  logic [NUM_PLAYERS-1:0] r_falseStart;

  // Jumping the gun during HOLD sticks until the round is cleared or re-armed.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_falseStart <= '0;
    end else if (clear) begin
      r_falseStart <= '0;
    end else if ((r_state == IDLE || r_state == TIMEOUT) && arm) begin
      r_falseStart <= '0;
    end else if (r_state == HOLD) begin
      r_falseStart <= r_falseStart | (w_press & r_mask);
    end
  end

  assign w_falseStart = r_falseStart;
`else
  assign w_falseStart = '0;
`endif

  always_comb begin
    w_led = '0;
    case (r_state)
      OPEN:    w_led = r_mask & ~w_falseStart;
      LOCKED:  w_led[r_winnerId] = 1'b1;
      default: ;
    endcase
  end

  assign state        = r_state;
  assign winner_valid = r_winnerValid;
  assign winner_id    = r_winnerId;
  assign timeout      = r_timeout;
  assign led          = w_led;
  assign false_start  = w_falseStart;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter with a winner scoreboard; covers the
// BUZZ_FALSE_START_EN behaviour when that macro is defined.
module tb_buzz_arbiter;
  import partybox_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  keyN;
  logic [3:0]  mask;
  logic        arm;
  logic        clear;
  buzz_state_t state;
  logic        winnerValid;
  logic [1:0]  winnerId;
  logic        timeout;
  logic [3:0]  led;
  logic [3:0]  falseStart;

  int total = 0;
  int bad   = 0;
  int expQ[$];

  always #5 clk = ~clk;

  buzz_arbiter #(
    .NUM_PLAYERS    (4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .WINDOW_CYCLES  (50)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .key_n       (keyN),
    .enable_mask (mask),
    .arm         (arm),
    .clear       (clear),
    .state       (state),
    .winner_valid(winnerValid),
    .winner_id   (winnerId),
    .timeout     (timeout),
    .led         (led),
    .false_start (falseStart)
  );

  // Every step lands 1 ns after a rising edge, so drives and samples stay clear of it.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] keys, input int expWinner);
    keyN = keys;
    if (expWinner >= 0) expQ.push_back(expWinner);
  endtask

  task automatic checkWinner(input string tag);
    int exp;
    checkOutput({tag, "_valid"}, 32'(winnerValid), 32'd1);
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_sb observed=%0d expected=empty-queue", tag, winnerId);
    end else begin
      exp = expQ.pop_front();
      checkOutput({tag, "_id"}, 32'(winnerId), 32'(exp));
    end
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic openRound(input string tag);
    pulseArm();
    checkOutput({tag, "_hold"}, 32'(state), 32'(HOLD));
    tick(10);
    checkOutput({tag, "_open"}, 32'(state), 32'(OPEN));
  endtask

  task automatic releaseAndClear(input string tag);
    applyStimulus(4'b1111, -1);
    tick(8);
    pulseClear();
    checkOutput({tag, "_idle"}, 32'(state), 32'(IDLE));
  endtask

  initial begin
    rst   = 1'b1;
    keyN  = 4'b1111;
    mask  = 4'b1111;
    arm   = 1'b0;
    clear = 1'b0;
    tick(3);
    checkOutput("rst_state", 32'(state), 32'(IDLE));
    checkOutput("rst_valid", 32'(winnerValid), 32'd0);
    checkOutput("rst_id", 32'(winnerId), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_led", 32'(led), 32'd0);
    checkOutput("rst_fs", 32'(falseStart), 32'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] simultaneous presses, rotating priority");
    openRound("t3a");
    applyStimulus(4'b0110, 0);
    tick(8);
    checkWinner("t3a");
    releaseAndClear("t3a");
    openRound("t3b");
    applyStimulus(4'b0110, 3);
    tick(8);
    checkWinner("t3b");
    releaseAndClear("t3b");

    $display("[TB] clean press latency");
    openRound("t1");
    applyStimulus(4'b1101, 1);
    tick(7);
    checkOutput("t1_early", 32'(winnerValid), 32'd0);
    tick(1);
    checkWinner("t1");
    checkOutput("t1_led", 32'(led), 32'b0010);
    checkOutput("t1_state", 32'(state), 32'(LOCKED));
    releaseAndClear("t1");
    checkOutput("t1_clrvalid", 32'(winnerValid), 32'd0);
    checkOutput("t1_holdid", 32'(winnerId), 32'd1);

    $display("[TB] bouncing key");
    openRound("t2");
    for (int i = 0; i < 3; i++) begin
      keyN = 4'b1011;
      tick(2);
      keyN = 4'b1111;
      tick(2);
    end
    checkOutput("t2_bounce", 32'(winnerValid), 32'd0);
    applyStimulus(4'b1011, 2);
    tick(7);
    checkOutput("t2_early", 32'(winnerValid), 32'd0);
    tick(1);
    checkWinner("t2");
    releaseAndClear("t2");

    $display("[TB] window timeout");
    pulseArm();
    tick(9);
    checkOutput("t4_holdlast", 32'(state), 32'(HOLD));
    tick(1);
    checkOutput("t4_open", 32'(state), 32'(OPEN));
    tick(49);
    checkOutput("t4_openlast", 32'(state), 32'(OPEN));
    checkOutput("t4_notyet", 32'(timeout), 32'd0);
    tick(1);
    checkOutput("t4_state", 32'(state), 32'(TIMEOUT));
    checkOutput("t4_pulse", 32'(timeout), 32'd1);
    tick(1);
    checkOutput("t4_pulseend", 32'(timeout), 32'd0);
    checkOutput("t4_stay", 32'(state), 32'(TIMEOUT));
    pulseArm();
    checkOutput("t4_rearm", 32'(state), 32'(HOLD));
    pulseClear();
    checkOutput("t4_clr", 32'(state), 32'(IDLE));

    $display("[TB] press in LOCKED, clear with arm");
    openRound("t5");
    applyStimulus(4'b1110, 0);
    tick(8);
    checkWinner("t5");
    applyStimulus(4'b1100, -1);
    tick(8);
    checkOutput("t5_locked", 32'(state), 32'(LOCKED));
    checkOutput("t5_keepid", 32'(winnerId), 32'd0);
    checkOutput("t5_led", 32'(led), 32'b0001);
    clear = 1'b1;
    arm   = 1'b1;
    tick(1);
    clear = 1'b0;
    arm   = 1'b0;
    checkOutput("t5_idle", 32'(state), 32'(IDLE));
    checkOutput("t5_valid", 32'(winnerValid), 32'd0);
    tick(3);
    checkOutput("t5_noround", 32'(state), 32'(IDLE));
    applyStimulus(4'b1111, -1);
    tick(8);

    $display("[TB] masked player");
    mask = 4'b1110;
    openRound("tm");
    checkOutput("tm_led", 32'(led), 32'b1110);
    applyStimulus(4'b1110, -1);
    tick(10);
    checkOutput("tm_ignored", 32'(winnerValid), 32'd0);
    applyStimulus(4'b1011, 2);
    tick(8);
    checkWinner("tm");
    releaseAndClear("tm");
    mask = 4'b1111;

    $display("[TB] press during HOLD");
    pulseArm();
    applyStimulus(4'b1011, -1);
    tick(10);
    checkOutput("t6_open", 32'(state), 32'(OPEN));
`ifdef BUZZ_FALSE_START_EN
    checkOutput("t6_fs", 32'(falseStart), 32'b0100);
    checkOutput("t6_led", 32'(led), 32'b1011);
    applyStimulus(4'b1111, -1);
    tick(8);
    applyStimulus(4'b1011, -1);
    tick(8);
    checkOutput("t6_dq", 32'(winnerValid), 32'd0);
    applyStimulus(4'b1010, 0);
    tick(8);
    checkWinner("t6");
    checkOutput("t6_fskeep", 32'(falseStart), 32'b0100);
    releaseAndClear("t6");
    checkOutput("t6_fsclr", 32'(falseStart), 32'd0);
`else
    checkOutput("t6_fs", 32'(falseStart), 32'd0);
    checkOutput("t6_led", 32'(led), 32'b1111);
    applyStimulus(4'b1010, 0);
    tick(8);
    checkWinner("t6");
    releaseAndClear("t6");
`endif

    $display("[TB] reset mid-round");
    openRound("tr");
    applyStimulus(4'b1101, 1);
    tick(8);
    checkWinner("tr");
    rst = 1'b1;
    tick(2);
    checkOutput("tr_state", 32'(state), 32'(IDLE));
    checkOutput("tr_valid", 32'(winnerValid), 32'd0);
    checkOutput("tr_id", 32'(winnerId), 32'd0);
    checkOutput("tr_led", 32'(led), 32'd0);
    rst = 1'b0;
    tick(8);
    checkOutput("tr_idle", 32'(state), 32'(IDLE));
    openRound("trh");
    tick(10);
    checkOutput("trh_held", 32'(winnerValid), 32'd0);
    applyStimulus(4'b1111, -1);
    tick(8);
    applyStimulus(4'b0110, 0);
    tick(8);
    checkWinner("trp");
    releaseAndClear("trp");

    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buzz_arbiter.md
Name: buzz_arbiter

Overview:
- Hardware buzzer controller for the quiz-style party games; shares the board's push-buttons between up to four players.
- Debounces raw active-low keys and runs a round: arm, get-ready hold, open window, then latch the first valid press.
- Locks out all other players until the Nios host clears the round.
- Exposes winner and round state as PIO-readable signals and drives LEDs directly.

Parameters:
NUM_PLAYERS, 4, number of player keys (1..8)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key change is accepted (10 ms @ 50 MHz)
HOLD_CYCLES, 50000000, get-ready period after arm (1 s)
WINDOW_CYCLES, 250000000, open window before timeout (5 s)

Ports:
clk_clk  in  1  system clock, 50 MHz
reset_reset  in  1  synchronous, active-high reset
key_n  in  NUM_PLAYERS  raw asynchronous player keys, active-low
enable_mask  in  NUM_PLAYERS  1 = player participates (from switches)
arm  in  1  one-cycle start-round pulse from host
clear  in  1  one-cycle abort/reset-round pulse from host
state  out  3  round state encoding (package enum)
winner_valid  out  1  high while a winner is latched
winner_id  out  $clog2(NUM_PLAYERS) (min 1)  index of latched winner
timeout  out  1  one-cycle pulse when the window expires
led  out  NUM_PLAYERS  player indicator LEDs
false_start  out  NUM_PLAYERS  players disqualified this round (optional feature)

Behaviour:
- Reset: state=IDLE; winner_valid=0; winner_id=0; timeout=0; led=0; false_start=0; priority pointer=0.
- All debouncers reset to "released"; all timers cleared.
- Key path: 2-flop synchronizer, then per-key stability counter.
- Debounced level toggles when the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- Press event: one-cycle pulse on a debounced released->pressed transition. Release generates no event.
- Latency: raw key_n low at edge k gives winner_valid high after edge k+DEBOUNCE_CYCLES+3.
- States and transitions:
  - IDLE: arm -> HOLD; all presses ignored.
  - HOLD: counts HOLD_CYCLES, then -> OPEN. Presses are handled per the optional feature.
  - OPEN: counts WINDOW_CYCLES. An eligible press -> LOCKED. On expiry -> TIMEOUT, with timeout pulsed 1 cycle on entry.
  - LOCKED: winner latched; stays until clear.
  - TIMEOUT: arm -> HOLD.
- Eligible press: enable_mask bit set AND not in false_start. Masked keys are ignored in every state.
- Simultaneous eligible presses in one cycle: rotating priority. The winner is the first requester at or after the pointer in ascending wrap order; the pointer then becomes (winner+1) mod NUM_PLAYERS.
- clear: from any state -> IDLE next cycle. Drops winner_valid and false_start. clear has priority over arm, press and expiry in the same cycle.
- arm in HOLD, OPEN or LOCKED is ignored.
- winner_id holds its last value after clear; it is meaningful only while winner_valid=1.
- A key held through arm produces no event; the player must release and re-press.
- led:
  - OPEN: enable_mask & ~false_start.
  - LOCKED: one-hot of winner_id.
  - HOLD, IDLE and TIMEOUT: 0.
- Timers are cleared on every state entry. The expiry test is count == N-1, so no wrap occurs.
- enable_mask changes take effect on the next cycle.
- reset_reset mid-round: full return to reset values, including the debouncers.

Optional Feature:
- Macro: BUZZ_FALSE_START_EN.
- When defined: an eligible press during HOLD sets that player's false_start bit and disqualifies the player until clear or the next arm. The bits are cleared on arm. If every enabled player is disqualified in OPEN, the block waits for the window timeout.
- When undefined: presses in HOLD are ignored, and false_start is tied to 0.

Decomposition:
- partybox_pkg holds:
  - typedef enum logic [2:0] buzz_state_t {IDLE, HOLD, OPEN, LOCKED, TIMEOUT};
  - function for the rotating-priority pick;
  - constant MAX_PLAYERS=8.
- Sub-module key_debounce: synchronizer, stability counter and press pulse. One instance per key, parameterized by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, WINDOW_CYCLES=50, NUM_PLAYERS=4, mask=4'b1111):
1. Arm, wait 10 cycles, press key1 clean at edge k -> winner_valid=1 and winner_id=1 at edge k+7; led=4'b0010; state=LOCKED.
2. Key2 bounces low/high every 2 cycles for 12 cycles, then stays low -> no event until 4 stable cycles; winner_id=2.
3. Key0 and key3 pressed on the same edge with pointer=0 -> winner 0, pointer becomes 1. Clear, arm, repeat -> winner 3.
4. Arm, no presses -> timeout pulse exactly 1 cycle at the 50th OPEN cycle; state=TIMEOUT; a new arm -> HOLD.
5. Key1 pressed in LOCKED, and clear with arm in the same cycle -> state=IDLE, winner_valid=0, no new round.
6. (BUZZ_FALSE_START_EN) key2 pressed during HOLD -> false_start=4'b0100, led in OPEN=4'b1011. Key2 pressed again in OPEN is ignored; key0 then wins.
